pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor for the CLA datapath family.

---
 rtl/pipelined_cla_adder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. Operands are prepared and
//   registered in a capture rank. Then NSTG = WIDTH/(BLOCK*BPS) stages each add
//   one BLOCK*BPS-bit slice, using the carry that the previous stage registered.
//   Every register rank holds together while the output is stalled.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = ~stall, combinational)
//   a, b, cin, sub        operands; sub=1 gives a-b and ignores cin
//   out_valid / out_ready result handshake
//   sum, cout, ovf, zero  result and flags (cout=1 on sub means no borrow)

module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4,
   parameter int BPS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int S    = BLOCK * BPS;
   localparam int NSTG = WIDTH / S;

   // One lookahead block. Every carry is a flat sum of products of g, p and the
   // block carry-in, so no carry ripples inside a block.
   // Returns {carry into block MSB, block carry-out, block sum}.
   function automatic logic [BLOCK+1:0] cla_block(input logic [BLOCK-1:0] a_i,
                                                  input logic [BLOCK-1:0] b_i,
                                                  input logic             c_i);
      logic [BLOCK-1:0] p;
      logic [BLOCK-1:0] g;
      logic [BLOCK:0]   c;
      logic             term;
      p    = a_i ^ b_i;
      g    = a_i & b_i;
      c    = '0;
      c[0] = c_i;
      for (int i = 0; i < BLOCK; i++) begin
         term = c_i;
         for (int j = 0; j <= i; j++) term = term & p[j];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
   endfunction

   logic             stall;

   // The sub flag is folded into cap_b (b inverted) and cap_c (forced to 1)
   // at capture, so it does not need its own register.
   logic             cap_valid_q, cap_valid_d;
   logic [WIDTH-1:0] cap_a_q, cap_a_d;
   logic [WIDTH-1:0] cap_b_q, cap_b_d;
   logic             cap_c_q, cap_c_d;

   logic [NSTG-1:0]  st_valid_q, st_valid_d;
   logic [NSTG-1:0]  st_c_q, st_c_d;
   logic [WIDTH-1:0] st_a_q   [NSTG];
   logic [WIDTH-1:0] st_a_d   [NSTG];
   logic [WIDTH-1:0] st_b_q   [NSTG];
   logic [WIDTH-1:0] st_b_d   [NSTG];
   logic [WIDTH-1:0] st_sum_q [NSTG];
   logic [WIDTH-1:0] st_sum_d [NSTG];
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   assign stall     = st_valid_q[NSTG-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = st_valid_q[NSTG-1];
   assign sum       = st_sum_q[NSTG-1];
   assign cout      = st_c_q[NSTG-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   always_comb begin
      cap_valid_d = cap_valid_q;
      cap_a_d     = cap_a_q;
      cap_b_d     = cap_b_q;
      cap_c_d     = cap_c_q;
      if (!stall) begin
         cap_valid_d = in_valid;
         cap_a_d     = a;
         cap_b_d     = sub ? ~b : b;
         cap_c_d     = sub ? 1'b1 : cin;
      end
   end

   always_comb begin
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_sum;
      logic             src_v;
      logic             c;
      logic             c_msb;
      logic [BLOCK+1:0] blk;
      int               kp;
      st_valid_d = st_valid_q;
      st_c_d     = st_c_q;
      st_a_d     = st_a_q;
      st_b_d     = st_b_q;
      st_sum_d   = st_sum_q;
      ovf_d      = ovf_q;
      zero_d     = zero_q;
      src_a      = '0;
      src_b      = '0;
      src_sum    = '0;
      src_v      = 1'b0;
      c          = 1'b0;
      c_msb      = 1'b0;
      blk        = '0;
      kp         = 0;
      if (!stall) begin
         for (int k = 0; k < NSTG; k++) begin
            kp = (k > 0) ? k - 1 : 0;
            if (k == 0) begin
               src_v   = cap_valid_q;
               src_a   = cap_a_q;
               src_b   = cap_b_q;
               src_sum = '0;
               c       = cap_c_q;
            end else begin
               src_v   = st_valid_q[kp];
               src_a   = st_a_q[kp];
               src_b   = st_b_q[kp];
               src_sum = st_sum_q[kp];
               c       = st_c_q[kp];
            end
            // Blocks inside a stage chain their block carry-outs.
            for (int j = 0; j < BPS; j++) begin
               blk = cla_block(src_a[k*S + j*BLOCK +: BLOCK],
                               src_b[k*S + j*BLOCK +: BLOCK], c);
               src_sum[k*S + j*BLOCK +: BLOCK] = blk[BLOCK-1:0];
               c     = blk[BLOCK];
               c_msb = blk[BLOCK+1];
            end
            st_valid_d[k] = src_v;
            st_a_d[k]     = src_a;
            st_b_d[k]     = src_b;
            st_sum_d[k]   = src_sum;
            st_c_d[k]     = c;
         end
         // c and c_msb now belong to the top block of the last stage.
         ovf_d  = c_msb ^ c;
         zero_d = st_valid_d[NSTG-1] & ~|st_sum_d[NSTG-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid_q <= 1'b0;
         cap_a_q     <= '0;
         cap_b_q     <= '0;
         cap_c_q     <= 1'b0;
         st_valid_q  <= '0;
         st_c_q      <= '0;
         for (int k = 0; k < NSTG; k++) begin
            st_a_q[k]   <= '0;
            st_b_q[k]   <= '0;
            st_sum_q[k] <= '0;
         end
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         cap_valid_q <= cap_valid_d;
         cap_a_q     <= cap_a_d;
         cap_b_q     <= cap_b_d;
         cap_c_q     <= cap_c_d;
         st_valid_q  <= st_valid_d;
         st_c_q      <= st_c_d;
         for (int k = 0; k < NSTG; k++) begin
            st_a_q[k]   <= st_a_d[k];
            st_b_q[k]   <= st_b_d[k];
            st_sum_q[k] <= st_sum_d[k];
         end
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

endmodule
